// File: rtl/rc5_key_mix_pkg.sv
// Shared RC5 constants and key-schedule FSM encoding.
package rc5_key_mix_pkg;
  localparam logic [31:0] P32   = 32'hB7E15163;
  localparam logic [31:0] Q32   = 32'h9E3779B9;
  localparam int          T_DEF = 26;
  localparam int          C_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2
  } state_e;
endpackage

// File: rtl/rc5_rotl.sv
// Variable left rotate by the low log2(w) bits of amt.
module rc5_rotl #(
  parameter int w = 32
) (
  input  logic [w-1:0]         din,
  input  logic [$clog2(w)-1:0] amt,
  output logic [w-1:0]         dout
);
  logic [2*w-1:0] dbl;

  // upper half of the shifted doubled word is the rotated value
  assign dbl  = {din, din} << amt;
  assign dout = dbl[2*w-1:w];
endmodule

// File: rtl/rc5_key_mix.sv
// RC5 key expansion: builds S from P/Q (INIT), then mixes key words into it (MIX).
module rc5_key_mix
  import rc5_key_mix_pkg::*;
#(
  parameter int w = 32,
  parameter int t = T_DEF,
  parameter int c = C_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] l0,
  input  logic [w-1:0] l1,
  input  logic [w-1:0] l2,
  input  logic [w-1:0] l3,
  input  logic [w-1:0] pW,
  input  logic [w-1:0] qW,
  input  logic [4:0]   rd_addr,
  output logic [w-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic         key_valid
);
  localparam int LW    = $clog2(w);
  localparam int IW    = (t > 1) ? $clog2(t) : 1;
  localparam int JW    = (c > 1) ? $clog2(c) : 1;
  localparam int ITERS = 3 * ((t > c) ? t : c);
  localparam int NW    = $clog2(ITERS);

  state_e              state_q, state_d;
  logic [w-1:0]        a_q, a_d, b_q, b_d, p_q, p_d, q_q, q_d, acc_q, acc_d;
  logic [c-1:0][w-1:0] l_q, l_d;
  logic [IW-1:0]       i_q, i_d;
  logic [JW-1:0]       j_q, j_d;
  logic [NW-1:0]       n_q, n_d;
  logic                busy_q, busy_d, done_q, done_d, kv_q, kv_d;
  logic [w-1:0]        rd_q, rd_d;

  logic [w-1:0]        s_mem [t];
  logic                s_we;
  logic [IW-1:0]       s_waddr;
  logic [w-1:0]        s_wdata;

  logic [3:0][w-1:0]   key_in;
  logic [w-1:0]        a_sum, a_new, b_sum, b_new, ab;

  assign key_in = {l3, l2, l1, l0};

  // one mix iteration: A from S[i], then B from L[j] using the new A
  assign a_sum = s_mem[i_q] + a_q + b_q;
  rc5_rotl #(.w(w)) u_rotl_a (.din(a_sum), .amt(LW'(3)), .dout(a_new));

  assign ab    = a_new + b_q;
  assign b_sum = l_q[j_q] + ab;
  rc5_rotl #(.w(w)) u_rotl_b (.din(b_sum), .amt(ab[LW-1:0]), .dout(b_new));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    q_d     = q_q;
    acc_d   = acc_q;
    l_d     = l_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    s_we    = 1'b0;
    s_waddr = i_q;
    s_wdata = a_new;
    rd_d    = (int'(rd_addr) < t) ? s_mem[IW'(rd_addr)] : '0;

    unique case (state_q)
      IDLE: begin
        // done_q high means this is the completion cycle; a start here is dropped
        if (start && !done_q) begin
          state_d = INIT;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          i_d     = '0;
          p_d     = pW;
          q_d     = qW;
          for (int k = 0; k < c; k++) l_d[k] = (k < 4) ? key_in[k[1:0]] : '0;
        end
      end
      INIT: begin
        s_we    = 1'b1;
        s_wdata = (i_q == '0) ? p_q : acc_q + q_q;
        acc_d   = s_wdata;
        if (i_q == IW'(t - 1)) begin
          state_d = MIX;
          i_d     = '0;
          j_d     = '0;
          n_d     = '0;
          a_d     = '0;
          b_d     = '0;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      MIX: begin
        s_we     = 1'b1;
        a_d      = a_new;
        b_d      = b_new;
        l_d[j_q] = b_new;
        i_d      = (i_q == IW'(t - 1)) ? '0 : i_q + IW'(1);
        j_d      = (j_q == JW'(c - 1)) ? '0 : j_q + JW'(1);
        n_d      = n_q + NW'(1);
        if (n_q == NW'(ITERS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      l_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      l_q     <= l_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      rd_q    <= rd_d;
    end
  end

  // table storage carries no reset
  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_waddr] <= s_wdata;
  end

  assign rd_data   = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;
endmodule

// File: doc/rc5_key_mix.md
RC5_KEY_MIX -- requirements
Module: rc5_key_mix

Interface
REQ-001 SHALL have parameter w, default 32: word width in bits (power of two).
REQ-002 SHALL have parameter t, default 26: S-table length, i.e. 2*(rounds+1).
REQ-003 SHALL have parameter c, default 4: key length in words.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: request a schedule using the current l0..l3, pW and qW.
REQ-007 SHALL have ports l0, l1, l2, l3  input  w each: key words L[0..3] from the key-bytes-to-words stage.
REQ-008 SHALL have ports pW, qW  input  w each: magic constants P and Q.
REQ-009 SHALL have port rd_addr  input  5: S-table read index.
REQ-010 SHALL have port rd_data  output  w: registered S[rd_addr].
REQ-011 SHALL have port busy  output  1: schedule in progress.
REQ-012 SHALL have port done  output  1: one-cycle completion pulse.
REQ-013 SHALL have port key_valid  output  1: S-table holds a complete schedule.

Function
REQ-014 SHALL implement the FSM IDLE -> INIT -> MIX -> IDLE; done pulses on the MIX -> IDLE transition.
REQ-015 SHALL, in IDLE with start=1 at edge N, capture l0..l3, pW and qW, clear key_valid, and enter INIT at N+1.
REQ-016 SHALL, in INIT, write S[0]=P, then S[i]=S[i-1]+Q mod 2^w, one word per cycle for t cycles, index 0..t-1.
REQ-017 SHALL, in MIX, perform 3*max(t,c) iterations, one per cycle: 78 for defaults.
REQ-018 SHALL compute each MIX iteration as A=S[i]=rotl(S[i]+A+B, 3), then B=L[j]=rotl(L[j]+A+B, (A+B) mod w).
REQ-019 SHALL start MIX with A=B=i=j=0 and advance i=(i+1) mod t, j=(j+1) mod c.
REQ-020 SHALL use the new A in the same iteration for B; the L and S updates commit on the same edge.
REQ-021 SHALL drop carries out of bit w-1 in all additions; the rotate amount SHALL use only the low log2(w) bits.
REQ-022 SHALL hold busy=1 from N+1 through the last MIX cycle, and SHALL assert done=1 and key_valid=1 at N+1+t+3*max(t,c) (N+105 for defaults).
REQ-023 SHALL ignore start while busy=1; a start on the same edge as done SHALL be ignored.
REQ-024 SHALL return rd_data=S[rd_addr] one cycle after rd_addr is sampled, regardless of state.
REQ-025 SHALL drive rd_data=0 when rd_addr>=t.
REQ-026 SHALL keep key_valid high until the next accepted start or reset.
REQ-027 SHALL ignore changes on l0..l3, pW and qW after capture.

Reset
REQ-028 SHALL, while rst=0, force state IDLE and busy=0, done=0, key_valid=0, rd_data=0, and A, B, i, j and the L registers to 0.
REQ-029 SHALL abandon an in-progress schedule when reset is asserted mid-INIT or mid-MIX; S contents are then undefined and key_valid SHALL stay 0.
REQ-030 SHALL leave S-table storage unreset.

Structure
REQ-031 SHALL place the P32=0xB7E15163 and Q32=0x9E3779B9 constants, the defaults for t and c, and the FSM state encoding in a shared rc5 package.
REQ-032 SHALL implement the variable left rotate as a single sub-module, rc5_rotl, parameterised by w.

Verification
REQ-033 SHALL cover: reset, then start with l0..l3=0, pW=0xB7E15163, qW=0x9E3779B9 -> busy at N+1 and done at N+105; S[0]=0xBF0A8B1D after the first MIX cycle; full table matches the software model.
REQ-034 SHALL cover: probe S[1] at the end of INIT -> 0x5618CB1C.
REQ-035 SHALL cover: start pulsed at N+10 and N+104 -> both ignored; single done at N+105.
REQ-036 SHALL cover: rst=0 at N+50, then released -> busy=0, key_valid=0, rd_data=0; a new start then completes in 105 cycles.
REQ-037 SHALL cover: rd_addr=25 and rd_addr=31 after done -> model S[25], then 0.
REQ-038 SHALL cover: non-zero key l0..l3=0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> all 26 words match the software model.
